stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Consumer end of the divided-clock interface: takes the slow toggling clocks `countclk` (1 Hz) and `adjclk` (2 Hz) and turns them into single-cycle enables in the `clk` domain.
- Maintains the MM:SS stopwatch value in BCD.
- Supports run/pause and per-field adjust mode.
- Digit outputs feed the 7-segment display mux, which is clocked by `fastclk` elsewhere.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for `countclk`/`adjclk`; legal range is 2 or more.
- MIN_MAX, 99, highest minutes value before wrap; legal range is 1-99.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- countclk  in  1  1 Hz toggling clock from the divider; asynchronous to this block
- adjclk  in  1  2 Hz toggling clock from the divider; asynchronous to this block
- pause_pulse  in  1  one-`clk` pulse from the debounced pause button
- adj  in  1  level; 1 = adjust mode
- sel  in  1  level; 0 = adjust minutes, 1 = adjust seconds
- min_tens  out  4  BCD minutes tens
- min_ones  out  4  BCD minutes ones
- sec_tens  out  4  BCD seconds tens (0-5)
- sec_ones  out  4  BCD seconds ones
- running  out  1  1 when in RUNNING state
- tick  out  1  one-`clk` pulse on any cycle the value changes

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - all digits 0, `running`=0, `tick`=0.
  - state is PAUSED.
  - synchronizer and edge flops are 0; `armed`=0.
- Input conditioning, per input:
  - SYNC_STAGES-flop synchronizer, then a previous-value flop.
  - Rising edge = synced & ~prev, giving `cnt_tick` / `adj_tick`.
  - `armed` sets after SYNC_STAGES+1 cycles following reset release.
  - Edges are ignored while `armed`=0, so an input that is high at reset produces no spurious tick.
- Latency: an input rising edge produces `tick` and the digit update SYNC_STAGES+1 `clk` cycles later.
- State machine (two states, PAUSED and RUNNING):
  - `pause_pulse`=1 toggles the state. This applies in adjust mode too.
  - On a cycle where `pause_pulse` and `cnt_tick` coincide, the tick is qualified by the state before the toggle.
- Count, when `adj`=0 and state is RUNNING and `cnt_tick`=1:
  - seconds +1 in BCD; ones 9→0 carries to tens.
  - seconds 59→00 carries +1 to minutes.
  - minutes at MIN_MAX with carry wrap to 00, so the value goes to 00:00.
- Adjust, when `adj`=1:
  - `cnt_tick` is ignored.
  - On `adj_tick`, the selected field increments by 1 with no carry into the other field.
  - Seconds wrap 59→00.
  - Minutes wrap MIN_MAX→00.
  - Adjust works in either run state.
- `sel` or `adj` changing on the same cycle as a tick: the values sampled on that cycle decide the action.
- `tick` is registered and asserted the same cycle the digits update. It is not asserted when the saturate feature blocks a change.
- Reset asserted mid-count: all outputs clear immediately, independent of `clk`.
- Digits never leave their BCD ranges: sec_tens 0-5, every other digit 0-9.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined:
  - Count mode holds at MIN_MAX:59 instead of wrapping.
  - On the blocked tick, `tick` stays 0 and the state forces to PAUSED.
  - Adjust mode still wraps as normal.
- Undefined: wrap to 00:00 as specified above.

Decomposition:
- Package `stopwatch_pkg`:
  - typedef `bcd_t` (4-bit).
  - state enum {PAUSED, RUNNING}.
  - constants SEL_MIN=0, SEL_SEC=1, SEC_MAX_TENS=5.
- Sub-module `edge_sync`:
  - synchronizer chain, prev flop and arm gating.
  - parameter SYNC_STAGES, output is a one-cycle rising-edge pulse.
  - instantiated twice, once for `countclk` and once for `adjclk`.

Test Plan:
- Reset while `countclk`=1 is held, release, wait 10 cycles -> `tick` never asserts and digits read 00:00.
- `pause_pulse` once, then 61 `countclk` rising edges -> 01:01, 61 `tick` pulses, each 3 cycles after its edge (SYNC_STAGES=2).
- Preload 99:59 via adjust, RUNNING, one `cnt_tick` -> 00:00. With STOPWATCH_SATURATE_EN: stays 99:59, `running`=0, no `tick`.
- `adj`=1, `sel`=1, start 00:58, three `adj_tick` -> 00:01 with minutes unchanged. Then `sel`=0, 2 `adj_tick` -> 02:01. `countclk` edges during adjust produce no change.
- `pause_pulse` coincident with `cnt_tick` while RUNNING at 00:05 -> 00:06 and state PAUSED. Next `cnt_tick` -> still 00:06.
- `rst_n` low mid-count at 12:34 -> 00:00 and `running`=0 within the same cycle, without waiting for a `clk` edge.

Source files
------------

// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } sw_state_e;

    localparam logic SEL_MIN      = 1'b0;
    localparam logic SEL_SEC      = 1'b1;
    localparam bcd_t SEC_MAX_TENS = 4'd5;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    // Two-digit BCD increment that wraps to 00 once the field is at its limit.
    function automatic bcd2_t bcd2_inc(input bcd2_t v, input bcd2_t lim);
        bcd2_t r;
        if (v == lim) begin
            r = '0;
        end else if (v.ones == 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control inputs and BCD display outputs of the stopwatch counter.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic countclk;
    logic adjclk;
    logic pause_pulse;
    logic adj;
    logic sel;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic running;
    logic tick;

    modport master (
        output countclk, adjclk, pause_pulse, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, running, tick
    );

    modport slave (
        input  countclk, adjclk, pause_pulse, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, running, tick
    );

endinterface

// File: rtl/stopwatch_counter_edge_sync.sv
// Synchronizes a slow asynchronous clock and emits a one-cycle rising-edge pulse,
// suppressed until the chain has flushed after reset.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   arm_q;
    logic                   armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Arming covers the window where an input held high through reset looks like an edge.
    assign armed  = arm_q[SYNC_STAGES];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q & armed;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause and per-field adjust.
// Define STOPWATCH_SATURATE_EN to hold at MIN_MAX:59 (and pause) instead of wrapping.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_MAX     = 99
) (
    input  logic clk,
    input  logic rst_n,
    stopwatch_if.slave bus
);

`ifdef STOPWATCH_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam bcd2_t SEC_LIM = bcd2_t'({SEC_MAX_TENS, 4'd9});
    localparam bcd2_t MIN_LIM = bcd2_t'({4'(MIN_MAX / 10), 4'(MIN_MAX % 10)});

    logic      cnt_tick;
    logic      adj_tick;
    sw_state_e state_q, state_d;
    bcd2_t     min_q, min_d;
    bcd2_t     sec_q, sec_d;
    logic      tick_q, tick_d;
    logic      at_max;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cnt_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.countclk),
        .rise_o(cnt_tick)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_adj_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.adjclk),
        .rise_o(adj_tick)
    );

    assign at_max = (sec_q == SEC_LIM) && (min_q == MIN_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAUSED;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
        end
    end

    // Count qualification uses state_q, so a coincident pause sees the pre-toggle state.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        if (bus.pause_pulse) state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
        if (bus.adj) begin
            if (adj_tick) begin
                tick_d = 1'b1;
                if (bus.sel == SEL_SEC) sec_d = bcd2_inc(sec_q, SEC_LIM);
                else                    min_d = bcd2_inc(min_q, MIN_LIM);
            end
        end else if (cnt_tick && state_q == RUNNING) begin
            if (SATURATE && at_max) begin
                state_d = PAUSED;
            end else begin
                tick_d = 1'b1;
                sec_d  = bcd2_inc(sec_q, SEC_LIM);
                if (sec_q == SEC_LIM) min_d = bcd2_inc(min_q, MIN_LIM);
            end
        end
    end

    assign bus.min_tens = min_q.tens;
    assign bus.min_ones = min_q.ones;
    assign bus.sec_tens = sec_q.tens;
    assign bus.sec_ones = sec_q.ones;
    assign bus.running  = (state_q == RUNNING);
    assign bus.tick     = tick_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed and randomized checks of stopwatch_counter against a seconds-based model.
module tb_stopwatch_counter;

    localparam int SYNC    = 2;
    localparam int MIN_MAX = 99;
    localparam int MAX_TOT = MIN_MAX * 60 + 59;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference state: minutes, seconds, run flag
    int m   = 0;
    int s   = 0;
    bit run = 0;

    stopwatch_if sw();

    stopwatch_counter #(.SYNC_STAGES(SYNC), .MIN_MAX(MIN_MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_digits();
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_digits"}, {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, exp_digits());
        check({tag, "_running"}, sw.running, run);
    endtask

    task automatic do_reset(input logic cclk);
        rst_n = 1'b0;
        sw.countclk = cclk; sw.adjclk = 1'b0;
        sw.pause_pulse = 1'b0; sw.adj = 1'b0; sw.sel = 1'b0;
        repeat (3) @(negedge clk);
        m = 0; s = 0; run = 0;
        check_state("in_reset");
        check("in_reset_tick", sw.tick, 1'b0);
        rst_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic pause();
        sw.pause_pulse = 1'b1;
        @(negedge clk);
        sw.pause_pulse = 1'b0;
        run = !run;
        check("pause_running", sw.running, run);
        check("pause_tick", sw.tick, 1'b0);
    endtask

    task automatic set_lvl(input logic a, input logic sl);
        sw.adj = a; sw.sel = sl;
        @(negedge clk);
    endtask

    // One rising edge on countclk (is_adj=0) or adjclk (is_adj=1), checked cycle by cycle.
    task automatic edge_pulse(input bit is_adj);
        bit chg = 0;
        int tot;
        if (is_adj) begin
            if (sw.adj) begin
                chg = 1;
                if (sw.sel) s = (s + 1) % 60;
                else        m = (m + 1) % (MIN_MAX + 1);
            end
        end else if (!sw.adj && run) begin
            tot = m * 60 + s;
            if (tot == MAX_TOT) begin
`ifdef STOPWATCH_SATURATE_EN
                run = 0;
`else
                tot = 0; chg = 1;
`endif
            end else begin
                tot++; chg = 1;
            end
            m = tot / 60; s = tot % 60;
        end
        if (is_adj) sw.adjclk = 1'b1; else sw.countclk = 1'b1;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(negedge clk);
            if (k <= SYNC) check("tick_early", sw.tick, 1'b0);
        end
        check("tick_latency", sw.tick, chg);
        check_state("edge");
        if (is_adj) sw.adjclk = 1'b0; else sw.countclk = 1'b0;
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            check("tick_single", sw.tick, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw.countclk = 1'b0; sw.adjclk = 1'b0;
        sw.pause_pulse = 1'b0; sw.adj = 1'b0; sw.sel = 1'b0;

        // countclk high across reset release must not tick
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("arm_no_tick", sw.tick, 1'b0);
        end
        check_state("arm");
        sw.countclk = 1'b0;
        repeat (3) @(negedge clk);

        // run 61 seconds
        pause();
        for (int i = 0; i < 61; i++) edge_pulse(0);
        check("run61", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0101);

        // randomized mix of operations
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: edge_pulse(0);
                3:       edge_pulse(1);
                4:       set_lvl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: pause();
            endcase
        end

        // preload MIN_MAX:59 then count once
        do_reset(1'b0);
        set_lvl(1'b1, 1'b0);
        for (int i = 0; i < MIN_MAX; i++) edge_pulse(1);
        set_lvl(1'b1, 1'b1);
        for (int i = 0; i < 59; i++) edge_pulse(1);
        check("preload", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h9959);
        set_lvl(1'b0, 1'b0);
        pause();
        edge_pulse(0);
`ifdef STOPWATCH_SATURATE_EN
        check("sat_hold", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h9959);
        check("sat_paused", sw.running, 1'b0);
`else
        check("wrap", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0000);
        check("wrap_running", sw.running, 1'b1);
`endif
        set_lvl(1'b1, 1'b0);
        edge_pulse(1);

        // adjust field wrap with no cross-field carry
        do_reset(1'b0);
        pause();
        set_lvl(1'b1, 1'b1);
        for (int i = 0; i < 58; i++) edge_pulse(1);
        for (int i = 0; i < 3; i++) edge_pulse(1);
        check("adj_sec_wrap", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0001);
        set_lvl(1'b1, 1'b0);
        edge_pulse(1);
        edge_pulse(1);
        check("adj_min", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0201);
        edge_pulse(0);
        edge_pulse(0);
        check("adj_ignores_cnt", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0201);

        // pause coincident with cnt_tick
        do_reset(1'b0);
        pause();
        for (int i = 0; i < 5; i++) edge_pulse(0);
        sw.countclk = 1'b1;
        repeat (SYNC) @(negedge clk);
        sw.pause_pulse = 1'b1;
        @(negedge clk);
        sw.pause_pulse = 1'b0;
        s = 6; run = 0;
        check("coinc_tick", sw.tick, 1'b1);
        check("coinc", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0006);
        check("coinc_paused", sw.running, 1'b0);
        sw.countclk = 1'b0;
        repeat (3) @(negedge clk);
        edge_pulse(0);
        check("after_coinc", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0006);

        // asynchronous reset mid-count at 12:34
        do_reset(1'b0);
        set_lvl(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) edge_pulse(1);
        set_lvl(1'b1, 1'b1);
        for (int i = 0; i < 34; i++) edge_pulse(1);
        set_lvl(1'b0, 1'b0);
        pause();
        sw.countclk = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        check("pre_rst_tick", sw.tick, 1'b1);
        check("pre_rst", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h1235);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digits", {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones}, 16'h0000);
        check("async_rst_running", sw.running, 1'b0);
        check("async_rst_tick", sw.tick, 1'b0);
        sw.countclk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
